// File: rtl/io_master_pkg.sv
// Shared types and constants for the I/O bus initiator: FSM encoding,
// mapped address windows and request-entry layout.
package io_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RESP
    } state_t;

    localparam int IO_AW   = 11;
    localparam int REQ_W   = 1 + IO_AW + 4 + 32;
    localparam int NUM_WIN = 4;

    // Inclusive [base, limit] windows that decode to a peripheral
    localparam logic [NUM_WIN-1:0][31:0] WIN_BASE  = {32'h400, 32'h020, 32'h010, 32'h000};
    localparam logic [NUM_WIN-1:0][31:0] WIN_LIMIT = {32'h4FF, 32'h027, 32'h013, 32'h00F};

    function automatic logic addr_mapped(input logic [31:0] addr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (addr >= WIN_BASE[i] && addr <= WIN_LIMIT[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/io_bus_master_if.sv
// Core-side request/response handshake plus I/O strobe bus of the initiator.
interface io_bus_master_if #(
    parameter int AW = 11
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_be;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          wr_err;
    logic          bus_read;
    logic          bus_write;
    logic [AW-1:0] bus_address;
    logic [3:0]    bus_be;
    logic [31:0]   bus_wdata;
    logic [31:0]   bus_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_be, req_wdata, rsp_ready, bus_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, wr_err,
               bus_read, bus_write, bus_address, bus_be, bus_wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_be, req_wdata, rsp_ready, bus_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, wr_err,
               bus_read, bus_write, bus_address, bus_be, bus_wdata
    );
endinterface

// File: rtl/io_req_fifo.sv
// Synchronous request FIFO, count-based full/empty, flushed by async rst_n.
module io_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 48
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [PW:0]             count;
    logic                    wr_en, rd_en;

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/io_bus_master.sv
// Queued single-beat initiator for the I/O window: SETUP/STROBE strobe cycles, held read response.
// Define IO_MASTER_STATS_EN to build the saturating read/write strobe counters.
module io_bus_master
    import io_master_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = IO_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    io_bus_master_if.master  bus,
    output logic [15:0]      stat_reads,
    output logic [15:0]      stat_writes
);
    localparam int EW = 1 + AW + 4 + 32;

    state_t        state_q, state_d;
    logic          push, pop, full, empty;
    logic [EW-1:0] din, dout;
    logic          cur_write;
    logic          mapped;
    logic          rd_stb, wr_stb;
    logic [31:0]   rdata_q;
    logic          err_q;

    assign push          = bus.req_valid && !full;
    assign bus.req_ready = !full;
    assign din           = {bus.req_write, bus.req_addr, bus.req_be, bus.req_wdata};

    io_req_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    assign mapped = addr_mapped(32'(bus.bus_address));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!empty) state_d = ST_SETUP;
            ST_SETUP: begin
                if (!mapped && cur_write) state_d = empty ? ST_IDLE : ST_SETUP;
                else if (!mapped)         state_d = ST_RESP;
                else                      state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (cur_write) state_d = empty ? ST_IDLE : ST_SETUP;
                else           state_d = ST_RESP;
            end
            ST_RESP:   if (bus.rsp_ready) state_d = empty ? ST_IDLE : ST_SETUP;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Every entry into SETUP (including SETUP->SETUP after a dropped write) starts a new request
    assign pop = (state_d == ST_SETUP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_write       <= 1'b0;
            bus.bus_address <= '0;
            bus.bus_be      <= '0;
            bus.bus_wdata   <= '0;
        end else if (pop) begin
            {cur_write, bus.bus_address, bus.bus_be, bus.bus_wdata} <= dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state_q == ST_SETUP && !mapped && !cur_write) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end else if (rd_stb) begin
            rdata_q <= bus.bus_rdata;
            err_q   <= 1'b0;
        end
    end

    assign rd_stb        = (state_q == ST_STROBE) && !cur_write;
    assign wr_stb        = (state_q == ST_STROBE) &&  cur_write;
    assign bus.bus_read  = rd_stb;
    assign bus.bus_write = wr_stb;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q && (state_q == ST_RESP);
    assign bus.wr_err    = (state_q == ST_SETUP) && !mapped && cur_write;

`ifdef IO_MASTER_STATS_EN
    logic [15:0] rd_cnt, wr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_stb && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 1'b1;
            if (wr_stb && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 1'b1;
        end
    end

    assign stat_reads  = rd_cnt;
    assign stat_writes = wr_cnt;
`else
    assign stat_reads  = 16'h0;
    assign stat_writes = 16'h0;
`endif

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: latency, unmapped handling, FIFO full, response hold, reset.
module tb_io_bus_master;
    import io_master_pkg::*;

    localparam int AW    = 11;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] stat_reads, stat_writes;

    always #5 clk = ~clk;

    io_bus_master_if #(.AW(AW)) bus_if ();

    io_bus_master #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if),
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log and protocol watch, sampled mid-cycle
    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [3:0]    be;
        logic [31:0]   d;
        int            c;
    } stb_t;

    stb_t stbq[$];
    int   viol = 0, rsp_rise = 0, wr_err_cyc = 0;
    logic prev_stb = 1'b0, prev_rv = 1'b0;

    always @(negedge clk) begin
        if (bus_if.bus_read && bus_if.bus_write) viol++;
        if (bus_if.bus_read || bus_if.bus_write) begin
            if (prev_stb) viol++;
            stbq.push_back('{bus_if.bus_write, bus_if.bus_address, bus_if.bus_be, bus_if.bus_wdata, cyc});
        end
        prev_stb = bus_if.bus_read || bus_if.bus_write;
        if (bus_if.rsp_valid && !prev_rv) rsp_rise++;
        prev_rv = bus_if.rsp_valid;
        if (bus_if.wr_err) wr_err_cyc++;
    end

    // Called at posedge+1; returns cycle number of the accepting edge
    task automatic push_req(input logic w, input logic [AW-1:0] a, input logic [3:0] be,
                            input logic [31:0] d, output int pc);
        int t;
        t = 0;
        bus_if.req_valid = 1'b1;
        bus_if.req_write = w;
        bus_if.req_addr  = a;
        bus_if.req_be    = be;
        bus_if.req_wdata = d;
        while (!bus_if.req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus_if.req_ready) chk("push_ready", 32'(bus_if.req_ready), 32'd1);
        @(posedge clk); #1;
        pc = cyc;
        bus_if.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int rc);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus_if.rsp_valid && t < 20);
        rc = cyc;
        if (!bus_if.rsp_valid) chk("rsp_seen", 32'(bus_if.rsp_valid), 32'd1);
    endtask

    task automatic accept_rsp();
        @(posedge clk); #1;
        bus_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic          m;
    } bnd_t;

    bnd_t        bnd[7];
    stb_t        s;
    int          pc, rc, n0, n1, r0, w0, t;
    logic        stable;
    logic [15:0] exp_rd, exp_wr;

    initial begin
        bus_if.req_valid = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_be    = '0;
        bus_if.req_wdata = '0;
        bus_if.rsp_ready = 1'b0;
        bus_if.bus_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("rst_strobes",   32'({bus_if.bus_read, bus_if.bus_write}), 32'd0);
        chk("rst_addr",      32'(bus_if.bus_address), 32'd0);
        chk("rst_wr_err",    32'(bus_if.wr_err), 32'd0);
        chk("rst_stats",     {stat_reads, stat_writes}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Mapped write: strobe two cycles after push, no response
        n0 = stbq.size(); r0 = rsp_rise;
        push_req(1'b1, 11'h010, 4'hF, 32'h12345678, pc);
        repeat (4) @(posedge clk); #1;
        chk("w1_nstb", 32'(stbq.size() - n0), 32'd1);
        s = stbq[n0];
        chk("w1_kind", 32'(s.w), 32'd1);
        chk("w1_addr", 32'(s.a), 32'h010);
        chk("w1_data", s.d, 32'h12345678);
        chk("w1_be",   32'(s.be), 32'hF);
        chk("w1_lat",  32'(s.c - pc), 32'd2);
        chk("w1_norsp", 32'(rsp_rise - r0), 32'd0);

        // Mapped read, response held 10 cycles with a write queued behind it
        bus_if.bus_rdata = 32'h0000A5A5;
        n0 = stbq.size();
        push_req(1'b0, 11'h010, 4'hF, 32'h0, pc);
        wait_rsp(rc);
        chk("r1_lat",   32'(rc - pc), 32'd3);
        chk("r1_rdata", bus_if.rsp_rdata, 32'h0000A5A5);
        chk("r1_err",   32'(bus_if.rsp_err), 32'd0);
        chk("r1_nstb",  32'(stbq.size() - n0), 32'd1);
        chk("r1_kind",  32'(stbq[n0].w), 32'd0);
        @(posedge clk); #1;
        push_req(1'b1, 11'h020, 4'h3, 32'hCAFEF00D, pc);
        bus_if.bus_rdata = 32'h11111111;
        n1 = stbq.size();
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bus_if.rsp_valid || bus_if.rsp_rdata !== 32'h0000A5A5 || bus_if.rsp_err) stable = 1'b0;
        end
        chk("hold_stable", 32'(stable), 32'd1);
        chk("hold_nostb",  32'(stbq.size() - n1), 32'd0);
        accept_rsp();
        repeat (4) @(posedge clk); #1;
        chk("hold_wr_nstb", 32'(stbq.size() - n1), 32'd1);
        chk("hold_wr_addr", 32'(stbq[n1].a), 32'h020);
        chk("hold_wr_data", stbq[n1].d, 32'hCAFEF00D);
        chk("hold_wr_be",   32'(stbq[n1].be), 32'h3);
        chk("hold_rsp_gone", 32'(bus_if.rsp_valid), 32'd0);

        // Unmapped read: error response with zero data, no strobe
        bus_if.bus_rdata = 32'hDEADBEEF;
        n0 = stbq.size();
        push_req(1'b0, 11'h200, 4'hF, 32'h0, pc);
        wait_rsp(rc);
        chk("ur_lat",   32'(rc - pc), 32'd2);
        chk("ur_rdata", bus_if.rsp_rdata, 32'h0);
        chk("ur_err",   32'(bus_if.rsp_err), 32'd1);
        chk("ur_nostb", 32'(stbq.size() - n0), 32'd0);
        accept_rsp();

        // Unmapped write: one wr_err cycle only
        w0 = wr_err_cyc; r0 = rsp_rise;
        push_req(1'b1, 11'h200, 4'hF, 32'h55AA55AA, pc);
        repeat (4) @(posedge clk); #1;
        chk("uw_wr_err", 32'(wr_err_cyc - w0), 32'd1);
        chk("uw_nostb",  32'(stbq.size() - n0), 32'd0);
        chk("uw_norsp",  32'(rsp_rise - r0), 32'd0);

        // Window edges
        bnd[0] = '{11'h00F, 1'b1};
        bnd[1] = '{11'h013, 1'b1};
        bnd[2] = '{11'h014, 1'b0};
        bnd[3] = '{11'h027, 1'b1};
        bnd[4] = '{11'h028, 1'b0};
        bnd[5] = '{11'h4FF, 1'b1};
        bnd[6] = '{11'h500, 1'b0};
        foreach (bnd[i]) begin
            n0 = stbq.size(); w0 = wr_err_cyc;
            push_req(1'b1, bnd[i].a, 4'h1, 32'(i), pc);
            repeat (4) @(posedge clk); #1;
            chk($sformatf("bnd_%0h_stb", bnd[i].a), 32'(stbq.size() - n0), 32'(bnd[i].m));
            chk($sformatf("bnd_%0h_err", bnd[i].a), 32'(wr_err_cyc - w0), 32'(!bnd[i].m));
        end

        // FIFO full behind a held read, then drain five writes in order
        bus_if.bus_rdata = 32'h5A5A0000;
        push_req(1'b0, 11'h000, 4'hF, 32'h0, pc);
        wait_rsp(rc);
        chk("f_rdata", bus_if.rsp_rdata, 32'h5A5A0000);
        @(posedge clk); #1;
        n0 = stbq.size();
        for (int i = 0; i < 4; i++) push_req(1'b1, 11'h400 + 11'(i), 4'hF, 32'hA0 + 32'(i), pc);
        chk("full_ready", 32'(bus_if.req_ready), 32'd0);
        bus_if.rsp_ready = 1'b1;
        push_req(1'b1, 11'h404, 4'hF, 32'hA4, pc);
        repeat (14) @(posedge clk); #1;
        bus_if.rsp_ready = 1'b0;
        chk("f_nstb", 32'(stbq.size() - n0), 32'd5);
        if (stbq.size() - n0 == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("f_addr%0d", i), 32'(stbq[n0+i].a), 32'h400 + 32'(i));
                chk($sformatf("f_data%0d", i), stbq[n0+i].d, 32'hA0 + 32'(i));
            end
            chk("f_gap", 32'(stbq[n0+1].c - stbq[n0].c), 32'd2);
        end

`ifdef IO_MASTER_STATS_EN
        exp_rd = 16'd2;
        exp_wr = 16'd11;
`else
        exp_rd = 16'd0;
        exp_wr = 16'd0;
`endif
        chk("stat_reads",  32'(stat_reads),  32'(exp_rd));
        chk("stat_writes", 32'(stat_writes), 32'(exp_wr));

        // Reset in the middle of a read strobe with writes still queued
        bus_if.rsp_ready = 1'b1;
        push_req(1'b0, 11'h400, 4'hF, 32'h0, pc);
        push_req(1'b1, 11'h401, 4'hF, 32'h1, pc);
        push_req(1'b1, 11'h402, 4'hF, 32'h2, pc);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus_if.bus_read && t < 10);
        chk("rs_in_strobe", 32'(bus_if.bus_read), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_strobes",   32'({bus_if.bus_read, bus_if.bus_write}), 32'd0);
        chk("rs_req_ready", 32'(bus_if.req_ready), 32'd1);
        chk("rs_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("rs_stats",     {stat_reads, stat_writes}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n1 = stbq.size();
        repeat (8) @(posedge clk); #1;
        chk("rs_flushed",   32'(stbq.size() - n1), 32'd0);
        chk("rs_ready_post", 32'(bus_if.req_ready), 32'd1);

        chk("strobe_protocol", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
